spmv_val_rd_arbiter: RTL and testbench
======================================

// Module: spmv_val_rd_arbiter
// PURPOSE
//  Read-only, in-order N:1 AXI4 arbiter. Merges the Val read channels of CONF_NUM_KERNEL spmv_calc_kernel
//  instances onto one HBM pseudo-channel, replacing the generic Val crossbar.
//  Round-robin AR arbitration and a bounded outstanding-burst order FIFO, so no AXI IDs are needed.
//  R beats are steered back to the kernel that issued each burst. Val write channels are tied off outside this block.
// PARAMETERS
//  CONF_NUM_KERNEL  4    number of kernel ports, 1..16
//  ADDR_W           48   AXI address width
//  DATA_W           256  AXI data width
//  MAX_OUTSTANDING  8    max accepted, not yet completed bursts (power of 2, 2..64)
// PORTS
//  clk              in   1                      single clock domain
//  rstn             in   1                      async active-low reset
//  s_axi_araddr     in   N*ADDR_W               per-kernel AR address, kernel i at [i*ADDR_W +: ADDR_W]
//  s_axi_arlen      in   N*8                    per-kernel burst length-1
//  s_axi_arsize     in   N*3                    per-kernel beat size
//  s_axi_arburst    in   N*2                    per-kernel burst type
//  s_axi_arvalid    in   N                      per-kernel AR valid
//  s_axi_arready    out  N                      per-kernel AR ready, at most one bit high
//  s_axi_rdata      out  N*DATA_W               R data, broadcast copy per kernel
//  s_axi_rresp      out  N*2                    R resp, broadcast
//  s_axi_rlast      out  N                      R last, broadcast
//  s_axi_rvalid     out  N                      R valid, only the owner's bit high
//  s_axi_rready     in   N                      per-kernel R ready
//  m_axi_araddr/arlen/arsize/arburst  out  ADDR_W/8/3/2  HBM AR payload, registered
//  m_axi_arvalid    out  1                      HBM AR valid
//  m_axi_arready    in   1                      HBM AR ready
//  m_axi_rdata/rresp/rlast  in  DATA_W/2/1      HBM R payload
//  m_axi_rvalid     in   1                      HBM R valid
//  m_axi_rready     out  1                      HBM R ready
//  outstanding      out  $clog2(MAX_OUTSTANDING)+1  bursts granted and not yet completed (rlast)
//  err_unexpected_r out  1                      sticky: R beat arrived while order FIFO empty
// BEHAVIOUR
//  Reset:
//   - m_axi_arvalid, s_axi_arready, s_axi_rvalid, m_axi_rready, outstanding and err_unexpected_r are all 0.
//   - The RR pointer is set so kernel 0 has top priority.
//   - Reset is async assert and sync deassert. Reset mid-burst drops all state; the HBM side must be reset together.
//  AR path:
//   - The output register is free when m_axi_arvalid==0 or (m_axi_arvalid && m_axi_arready).
//   - Grant condition: register free AND outstanding < MAX_OUTSTANDING AND |s_axi_arvalid.
//   - On grant, pick the first requester at or after last_grant+1 (mod N).
//   - Same cycle: s_axi_arready[g]=1 (combinational), the payload loads into the m_axi_ar* register, g is pushed into the order FIFO, last_grant<=g.
//   - Latency is 1 cycle from s handshake to m_axi_arvalid. Back-to-back grants reach 1 per cycle when m_axi_arready stays high.
//   - m_axi_ar* is held stable while arvalid && !arready.
//   - With outstanding==MAX_OUTSTANDING, all s_axi_arready are 0 until a burst completes. Pop and grant may occur in the same cycle.
//  R path:
//   - h = order FIFO head.
//   - s_axi_rvalid[h] = m_axi_rvalid && !empty; all other bits are 0.
//   - m_axi_rready = !empty && s_axi_rready[h]. Zero latency, pure pass-through; no R buffering.
//   - The FIFO pops on m_axi_rvalid && m_axi_rready && m_axi_rlast.
//   - If m_axi_rvalid is high with an empty FIFO, m_axi_rready stays 0 and err_unexpected_r sets (cleared only by reset).
//  Counting:
//   - outstanding = push - pop. A simultaneous push and pop leaves it unchanged.
//   - FIFO pointers wrap modulo MAX_OUTSTANDING.
//  Ordering: HBM returns bursts in AR order (single ID), so R routing follows grant order exactly.
// TESTING
//  1. Single kernel: k2 issues araddr=0x1000, arlen=3.
//     -> m_axi_arvalid is high the next cycle with addr 0x1000; 4 beats reach only s_axi_rvalid[2]; outstanding goes 1->0 after rlast.
//  2. All 4 kernels assert arvalid continuously, m_axi_arready=1.
//     -> grant order is 0,1,2,3,0,...; each kernel gets exactly one grant per 4 cycles.
//  3. MAX_OUTSTANDING=8, R held off (m_axi_rvalid=0), continuous requests.
//     -> exactly 8 grants, then s_axi_arready==0. First rlast -> 9th grant is accepted in the same cycle as the pop.
//  4. Kernel 1 deasserts s_axi_rready mid-burst.
//     -> m_axi_rready drops the same cycle; no beat is lost or duplicated; other kernels' rvalid stay 0.
//  5. m_axi_arready=0 for 5 cycles after arvalid.
//     -> m_axi_ar* stable throughout; no further s_axi_arready pulses.
//  6. Inject m_axi_rvalid=1 with no outstanding burst -> err_unexpected_r=1 and m_axi_rready=0.
//     Assert rstn=0 mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/spmv_val_rd_arbiter.sv
// In-order N:1 AXI4 read arbiter for the SpMV Val channels: round-robin AR grant into a
// registered HBM AR slot, with an order FIFO that steers R bursts back to their issuing kernel.
module spmv_val_rd_arbiter #(
  parameter int unsigned CONF_NUM_KERNEL = 4,
  parameter int unsigned ADDR_W          = 48,
  parameter int unsigned DATA_W          = 256,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [CONF_NUM_KERNEL*ADDR_W-1:0]   s_axi_araddr,
  input  logic [CONF_NUM_KERNEL*8-1:0]        s_axi_arlen,
  input  logic [CONF_NUM_KERNEL*3-1:0]        s_axi_arsize,
  input  logic [CONF_NUM_KERNEL*2-1:0]        s_axi_arburst,
  input  logic [CONF_NUM_KERNEL-1:0]          s_axi_arvalid,
  output logic [CONF_NUM_KERNEL-1:0]          s_axi_arready,
  output logic [CONF_NUM_KERNEL*DATA_W-1:0]   s_axi_rdata,
  output logic [CONF_NUM_KERNEL*2-1:0]        s_axi_rresp,
  output logic [CONF_NUM_KERNEL-1:0]          s_axi_rlast,
  output logic [CONF_NUM_KERNEL-1:0]          s_axi_rvalid,
  input  logic [CONF_NUM_KERNEL-1:0]          s_axi_rready,
  output logic [ADDR_W-1:0]                   m_axi_araddr,
  output logic [7:0]                          m_axi_arlen,
  output logic [2:0]                          m_axi_arsize,
  output logic [1:0]                          m_axi_arburst,
  output logic                                m_axi_arvalid,
  input  logic                                m_axi_arready,
  input  logic [DATA_W-1:0]                   m_axi_rdata,
  input  logic [1:0]                          m_axi_rresp,
  input  logic                                m_axi_rlast,
  input  logic                                m_axi_rvalid,
  output logic                                m_axi_rready,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
  output logic                                err_unexpected_r
);

  localparam int unsigned N  = CONF_NUM_KERNEL;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);

  logic [KW-1:0]   fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     cnt_q;
  logic [KW-1:0]   last_grant_q;

  logic [KW-1:0]   start, grant_idx, head;
  logic            found, ar_free, grant, empty, full, pop, sel_rready;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]      sel_len;
  logic [2:0]      sel_size;
  logic [1:0]      sel_burst;

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == (PW+1)'(MAX_OUTSTANDING));
  assign head        = fifo_q[rd_ptr_q];
  assign outstanding = cnt_q;

  assign s_axi_rdata = {CONF_NUM_KERNEL{m_axi_rdata}};
  assign s_axi_rresp = {CONF_NUM_KERNEL{m_axi_rresp}};
  assign s_axi_rlast = {CONF_NUM_KERNEL{m_axi_rlast}};

  // Round-robin: first requester at or after start, then wrap around from kernel 0.
  always_comb begin
    start     = (last_grant_q == KW'(N-1)) ? '0 : last_grant_q + KW'(1);
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && s_axi_arvalid[k] && (KW'(k) >= start)) begin
        grant_idx = KW'(k);
        found     = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && s_axi_arvalid[k]) begin
        grant_idx = KW'(k);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rready = 1'b0;
    sel_addr   = '0;
    sel_len    = '0;
    sel_size   = '0;
    sel_burst  = '0;
    for (int k = 0; k < N; k++) begin
      if (head == KW'(k)) sel_rready = s_axi_rready[k];
      if (grant_idx == KW'(k)) begin
        sel_addr  = s_axi_araddr[k*ADDR_W +: ADDR_W];
        sel_len   = s_axi_arlen[k*8 +: 8];
        sel_size  = s_axi_arsize[k*3 +: 3];
        sel_burst = s_axi_arburst[k*2 +: 2];
      end
    end
  end

  assign m_axi_rready = !empty && sel_rready;
  assign pop          = m_axi_rvalid && m_axi_rready && m_axi_rlast;
  assign ar_free      = !m_axi_arvalid || m_axi_arready;
  // rstn gating keeps arready low while reset is asserted even if requests are present.
  assign grant        = rstn && ar_free && (!full || pop) && found;

  always_comb begin
    s_axi_arready = '0;
    s_axi_rvalid  = '0;
    for (int k = 0; k < N; k++) begin
      s_axi_arready[k] = grant && (grant_idx == KW'(k));
      s_axi_rvalid[k]  = m_axi_rvalid && !empty && (head == KW'(k));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_axi_arvalid    <= 1'b0;
      m_axi_araddr     <= '0;
      m_axi_arlen      <= '0;
      m_axi_arsize     <= '0;
      m_axi_arburst    <= '0;
      last_grant_q     <= KW'(N-1);
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      cnt_q            <= '0;
      err_unexpected_r <= 1'b0;
    end else begin
      if (grant) begin
        m_axi_arvalid <= 1'b1;
        m_axi_araddr  <= sel_addr;
        m_axi_arlen   <= sel_len;
        m_axi_arsize  <= sel_size;
        m_axi_arburst <= sel_burst;
        wr_ptr_q      <= wr_ptr_q + PW'(1);
        last_grant_q  <= grant_idx;
      end else if (m_axi_arready) begin
        m_axi_arvalid <= 1'b0;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (grant && !pop) begin
        cnt_q <= cnt_q + (PW+1)'(1);
      end else if (!grant && pop) begin
        cnt_q <= cnt_q - (PW+1)'(1);
      end
      if (m_axi_rvalid && empty) err_unexpected_r <= 1'b1;
    end
  end

  // Order storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (grant) fifo_q[wr_ptr_q] <= grant_idx;
  end

endmodule

// File: tb/tb_spmv_val_rd_arbiter.sv
// Randomized bench for spmv_val_rd_arbiter against a queue-based model of grant order,
// the registered AR slot and an in-order HBM that returns bursts beat by beat.
module tb_spmv_val_rd_arbiter;
  localparam int N  = 4;
  localparam int AW = 48;
  localparam int DW = 256;
  localparam int MO = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N*AW-1:0]   s_axi_araddr;
  logic [N*8-1:0]    s_axi_arlen;
  logic [N*3-1:0]    s_axi_arsize;
  logic [N*2-1:0]    s_axi_arburst;
  logic [N-1:0]      s_axi_arvalid;
  logic [N-1:0]      s_axi_arready;
  logic [N*DW-1:0]   s_axi_rdata;
  logic [N*2-1:0]    s_axi_rresp;
  logic [N-1:0]      s_axi_rlast;
  logic [N-1:0]      s_axi_rvalid;
  logic [N-1:0]      s_axi_rready;
  logic [AW-1:0]     m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DW-1:0]     m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [$clog2(MO):0] outstanding;
  logic              err_unexpected_r;

  spmv_val_rd_arbiter #(
    .CONF_NUM_KERNEL(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .outstanding(outstanding), .err_unexpected_r(err_unexpected_r)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int          last;
  int          ord[$];       // kernels granted, not yet completed
  int          hbm_len[$];   // arlen of bursts accepted by HBM, not yet returned
  int          beat;
  bit          mv;
  logic [AW-1:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  bit          merr;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    last = N - 1;
    ord.delete();
    hbm_len.delete();
    beat = 0;
    mv = 0;
    m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
    merr = 0;
  endtask

  task automatic inputs_idle();
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arvalid = '0; s_axi_rready = '0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
  endtask

  // mode: 0 random, 1 fill (R held off), 2 saturate with R flowing, 3 drain, 4 inject stray R
  task automatic step(input int mode);
    logic [63:0]  t;
    logic [N-1:0] e_ar, e_rv;
    bit           empty, e_rready, free, pop, ok;
    int           g, h;
    @(negedge clk);
    check("ar_valid", m_axi_arvalid, mv);
    if (mv) begin
      check("ar_addr", m_axi_araddr, m_addr);
      check("ar_len", m_axi_arlen, m_len);
      check("ar_size_burst", {m_axi_arsize, m_axi_arburst}, {m_size, m_burst});
    end
    check("outstanding", outstanding, ord.size());
    check("err_sticky", err_unexpected_r, merr);

    for (int k = 0; k < N; k++) begin
      t = {$urandom(), $urandom()};
      s_axi_araddr[k*AW +: AW] = t[AW-1:0];
      s_axi_arlen[k*8 +: 8]    = 8'($urandom_range(0, 3));
      s_axi_arsize[k*3 +: 3]   = 3'($urandom);
      s_axi_arburst[k*2 +: 2]  = 2'($urandom);
    end
    for (int w = 0; w < DW / 32; w++) m_axi_rdata[w*32 +: 32] = $urandom();
    m_axi_rresp = 2'($urandom);
    case (mode)
      0: begin
        s_axi_arvalid = N'($urandom);
        m_axi_arready = ($urandom_range(0, 9) < 7);
        s_axi_rready  = N'($urandom) | N'($urandom);
        m_axi_rvalid  = (hbm_len.size() > 0) && ($urandom_range(0, 3) != 0);
      end
      1: begin
        s_axi_arvalid = '1; m_axi_arready = 1'b1; s_axi_rready = '1; m_axi_rvalid = 1'b0;
      end
      2: begin
        s_axi_arvalid = '1; m_axi_arready = 1'b1; s_axi_rready = '1;
        m_axi_rvalid  = (hbm_len.size() > 0);
      end
      3: begin
        s_axi_arvalid = '0; m_axi_arready = 1'b1; s_axi_rready = '1;
        m_axi_rvalid  = (hbm_len.size() > 0);
      end
      default: begin
        s_axi_arvalid = '0; m_axi_arready = 1'b1; s_axi_rready = '1; m_axi_rvalid = 1'b1;
      end
    endcase
    if (hbm_len.size() > 0) m_axi_rlast = (beat == hbm_len[0]);
    else                    m_axi_rlast = 1'($urandom);
    #1;

    empty    = (ord.size() == 0);
    h        = empty ? 0 : ord[0];
    e_rv     = '0;
    if (m_axi_rvalid && !empty) e_rv[h] = 1'b1;
    e_rready = !empty && s_axi_rready[h];
    pop      = m_axi_rvalid && e_rready && m_axi_rlast;
    free     = !mv || m_axi_arready;
    g        = -1;
    for (int i = 1; i <= N; i++) begin
      if (g < 0 && s_axi_arvalid[(last + i) % N]) g = (last + i) % N;
    end
    ok   = free && (g >= 0) && ((ord.size() < MO) || pop);
    e_ar = '0;
    if (ok) e_ar[g] = 1'b1;
    check("s_arready", s_axi_arready, e_ar);
    check("s_rvalid", s_axi_rvalid, e_rv);
    check("m_rready", m_axi_rready, e_rready);
    if (m_axi_rvalid) begin
      for (int k = 0; k < N; k++) check("rdata_bcast", s_axi_rdata[k*DW +: DW], m_axi_rdata);
      check("rresp_rlast_bcast", {s_axi_rresp, s_axi_rlast}, {{N{m_axi_rresp}}, {N{m_axi_rlast}}});
    end

    if (m_axi_rvalid && empty) merr = 1;
    if (m_axi_rvalid && e_rready) begin
      if (m_axi_rlast) begin
        void'(hbm_len.pop_front());
        beat = 0;
      end else begin
        beat++;
      end
    end
    if (pop) void'(ord.pop_front());
    if (mv && m_axi_arready) begin
      hbm_len.push_back(int'(m_len));
      mv = 0;
    end
    if (ok) begin
      mv      = 1;
      m_addr  = s_axi_araddr[g*AW +: AW];
      m_len   = s_axi_arlen[g*8 +: 8];
      m_size  = s_axi_arsize[g*3 +: 3];
      m_burst = s_axi_arburst[g*2 +: 2];
      ord.push_back(g);
      last    = g;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
    check({tag, "_arready"}, s_axi_arready, '0);
    check({tag, "_rvalid"}, s_axi_rvalid, '0);
    check({tag, "_rready"}, m_axi_rready, 1'b0);
    check({tag, "_outstanding"}, outstanding, '0);
    check({tag, "_err"}, err_unexpected_r, 1'b0);
  endtask

  initial begin
    int cnt;
    inputs_idle();
    model_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    s_axi_arvalid = '1;
    #1;
    check_reset_outputs("reset");
    s_axi_arvalid = '0;
    @(negedge clk);
    rstn = 1'b1;

    repeat (1500) step(0);
    repeat (15) step(1);
    repeat (60) step(2);
    repeat (1000) step(0);

    cnt = 0;
    while ((ord.size() > 0 || mv) && cnt < 300) begin
      step(3);
      cnt++;
    end
    check("drain_timeout", (cnt >= 300), 1'b0);
    repeat (3) step(4);
    repeat (30) step(0);

    // Asynchronous reset in the middle of traffic.
    @(negedge clk);
    s_axi_arvalid = '1;
    m_axi_rvalid  = 1'b1;
    s_axi_rready  = '1;
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    inputs_idle();
    @(negedge clk);
    rstn = 1'b1;

    repeat (300) step(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
